fsqrt_iter: RTL and testbench
=============================

FSQRT_ITER -- requirements
Module: fsqrt_iter

Interface
REQ-001 SHALL have parameter ITERS, default 2, meaning the number of Newton steps for the reciprocal square root (legal 1..4).
REQ-002 SHALL have parameter SEED_BITS, default 7, meaning the number of leading mantissa bits that index the seed table (legal 5..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, 32 bits: IEEE-754 single operand.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is held.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port out_data, output, 32 bits: IEEE-754 single result.

Function
REQ-011 SHALL be an FSM with states IDLE, SEED, ITER and ROUND, plus a DONE state for holding the result.
REQ-012 Transitions SHALL be:
- IDLE->SEED on in_valid&&in_ready.
- SEED->ITER after 1 cycle.
- ITER->ROUND after ITERS cycles, with a step counter 0..ITERS-1.
- ROUND->DONE after 1 cycle.
- DONE->IDLE on out_ready.
REQ-013 in_ready SHALL be 1 only in IDLE; the operand SHALL be registered at accept, so in_data is don't-care afterwards.
REQ-014 Latency SHALL be fixed: out_valid rises exactly ITERS+2 cycles after the accept edge.
REQ-015 out_valid SHALL be 1 only in DONE; out_data SHALL stay stable while out_valid&&!out_ready.
REQ-016 SHALL accept no new operand while DONE; a new accept is possible the cycle after the out handshake (throughput 1 per ITERS+4 cycles minimum).
REQ-017 Exponent: E=e-127 in signed 10-bit arithmetic. If E is odd, the significand {1,m} SHALL be doubled and E decremented. Result exponent = E/2+127 (exact, since E is even).
REQ-018 Seed: a combinational table indexed by {E parity, m[22:23-SEED_BITS]} SHALL give 1/sqrt of the bucket midpoint, SEED_BITS significant bits, with low bits zero.
REQ-019 Each ITER cycle SHALL compute x'=x*(3-a*x*x)/2 in unsigned fixed point with at least 32 fraction bits; all intermediate products SHALL be truncated, never wrapped.
REQ-020 ROUND SHALL compute y=a*x and round to 23 fraction bits with round-to-nearest-even using ulp, guard, round and sticky.
REQ-021 If the rounding carries out of the mantissa, the exponent SHALL increment and the mantissa SHALL become 0.
REQ-022 For positive normal inputs with ITERS>=2 and SEED_BITS>=7, the result SHALL be within 1 ulp of the correctly rounded sqrt.
REQ-023 A negative input, excluding -0, SHALL yield 0x80000000 (legacy code), unless REQ-029 applies.
REQ-024 Special-case results SHALL still take the full ITERS+2 latency, so latency is data-independent.

Reset
REQ-025 On rst=1 at a clock edge the state SHALL become IDLE, the step counter 0, out_valid 0 and out_data 32'h0; in_ready SHALL be 1 from the following cycle.
REQ-026 Reset asserted mid-operation, in any state, SHALL discard the operation with no out_valid pulse.
REQ-027 rst SHALL dominate in_valid when both are asserted in the same cycle.

Configuration
REQ-028 SHALL use macro FSQRT_SPECIAL_EN to select IEEE special-case handling.
REQ-029 With FSQRT_SPECIAL_EN defined, the following SHALL apply:
- +-0 and denormals (flushed to zero) -> +-0 with the sign preserved.
- +inf -> 0x7F800000.
- NaN, or any negative nonzero -> 0x7FC00000.
REQ-030 Without FSQRT_SPECIAL_EN, only REQ-023 SHALL apply. Zero, inf and NaN SHALL go through the Newton path, and their results are unspecified.

Verification
REQ-031 rst held 3 cycles, release -> out_valid=0, out_data=0x00000000, in_ready=1.
REQ-032 ITERS=2: 0x40800000 (4.0) accepted at cycle T -> out_valid at T+4, out_data=0x40000000; 0x3E800000 (0.25) -> 0x3F000000.
REQ-033 0x40000000 (2.0) -> 0x3FB504F3 within 1 ulp; sweep 10^5 random positive normals against a reference model, max error 1 ulp.
REQ-034 out_ready=0 for 5 cycles after out_valid -> out_data constant, in_ready=0, and a driven in_valid is ignored; the out handshake then gives in_ready=1 the next cycle.
REQ-035 0xBF800000 (-1.0) -> 0x7FC00000 with FSQRT_SPECIAL_EN, 0x80000000 without; 0x7F800000 -> 0x7F800000 with the macro.
REQ-036 rst pulsed during ITER -> no out_valid; the next operand 0x40800000 -> 0x40000000 at the nominal latency.

Source files
------------

// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 single square root: seed table, Newton reciprocal sqrt, y = a*x, RNE.
// Define FSQRT_SPECIAL_EN for IEEE zero/denormal/inf/NaN handling; otherwise only negatives are trapped.
module fsqrt_iter #(
  parameter int ITERS     = 2,
  parameter int SEED_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);
  // state | meaning: IDLE accept | SEED table lookup | ITER Newton step | ROUND a*x + RNE | DONE hold result
  typedef enum logic [2:0] {IDLE, SEED, ITER, ROUND, DONE} state_t;

  localparam int XW = 36;           // x: 4 integer bits, 32 fraction bits
  localparam int AW = 25;           // a: 2 integer bits, 23 fraction bits
  localparam int IW = SEED_BITS + 1;
  localparam logic [37:0] THREE = 38'h3_0000_0000;

  state_t          state, state_nxt;
  logic [2:0]      step;
  logic [AW-1:0]   a_q;
  logic [XW-1:0]   x;
  logic [IW-1:0]   seed_idx;
  logic [9:0]      res_exp;
  logic            spec;
  logic [31:0]     spec_val;

  // Rounded 1/sqrt of the bucket midpoint, scaled by 2^SEED_BITS.
  function automatic logic [IW-1:0] seed_calc(input int idx);
    logic [63:0] m, num, r, b;
    m = 64'(2 ** IW) + 64'(2 * (idx % (2 ** SEED_BITS)) + 1);
    if (idx >= 2 ** SEED_BITS) m = m << 1;
    num = (64'd1 << (3 * SEED_BITS + 3)) / m;
    r = 64'd0;
    for (int i = 20; i >= 0; i--) begin
      b = r | (64'd1 << i);
      if (b * b <= num) r = b;
    end
    r = (r + 64'd1) >> 1;
    return IW'(r);
  endfunction

  logic [IW-1:0] seed_rom [2**IW];
  for (genvar g = 0; g < 2**IW; g++) begin : g_seed
    localparam logic [IW-1:0] SEED_V = seed_calc(g);
    assign seed_rom[g] = SEED_V;
  end

  // Operand decode at accept
  logic [9:0]    e_in, e_even, half_exp;
  logic          odd_in;
  logic [AW-1:0] a_in;
  assign e_in     = {2'b00, in_data[30:23]} - 10'd127;
  assign odd_in   = e_in[0];
  assign e_even   = e_in - {9'b0, odd_in};
  assign half_exp = {e_even[9], e_even[9:1]} + 10'd127;
  assign a_in     = odd_in ? {1'b1, in_data[22:0], 1'b0} : {1'b0, 1'b1, in_data[22:0]};

  logic        sp_in;
  logic [31:0] sp_val_in;
  always_comb begin
    sp_in     = 1'b0;
    sp_val_in = 32'h0;
`ifdef FSQRT_SPECIAL_EN
    if (in_data[30:23] == 8'h00) begin
      sp_in = 1'b1; sp_val_in = {in_data[31], 31'h0};
    end else if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'h0) begin
      sp_in = 1'b1; sp_val_in = 32'h7FC00000;
    end else if (in_data[31]) begin
      sp_in = 1'b1; sp_val_in = 32'h7FC00000;
    end else if (in_data[30:23] == 8'hFF) begin
      sp_in = 1'b1; sp_val_in = 32'h7F800000;
    end
`else
    if (in_data[31] && in_data[30:0] != 31'h0) begin
      sp_in = 1'b1; sp_val_in = 32'h80000000;
    end
`endif
  end

  // Newton step x' = x*(3 - a*x*x)/2, every product truncated
  logic [2*XW-1:0]  sq, prod;
  logic [XW-1:0]    t1, x_nxt;
  logic [AW+XW-1:0] ax2, y;
  logic [37:0]      t2, diff;
  assign sq    = {{XW{1'b0}}, x} * {{XW{1'b0}}, x};
  assign t1    = sq[XW+31:32];
  assign ax2   = {{XW{1'b0}}, a_q} * {{AW{1'b0}}, t1};
  assign t2    = ax2[AW+XW-1:23];
  assign diff  = (t2 >= THREE) ? 38'h0 : THREE - t2;
  assign prod  = {{XW{1'b0}}, x} * {{XW{1'b0}}, diff[XW-1:0]};
  assign x_nxt = prod[XW+32:33];

  // y = a*x has 55 fraction bits; it may fall just below 1.0
  logic        norm, g_bit, r_bit, s_bit, rnd_up, carry;
  logic [22:0] mant_raw, mant_f;
  logic [23:0] rnd;
  logic [9:0]  exp_f;
  assign y        = {{XW{1'b0}}, a_q} * {{AW{1'b0}}, x};
  assign norm     = y[55];
  assign mant_raw = norm ? y[54:32] : y[53:31];
  assign g_bit    = norm ? y[31] : y[30];
  assign r_bit    = norm ? y[30] : y[29];
  assign s_bit    = norm ? |y[29:0] : |y[28:0];
  assign rnd_up   = g_bit && (r_bit || s_bit || mant_raw[0]);
  assign rnd      = {1'b0, mant_raw} + {23'b0, rnd_up};
  assign carry    = rnd[23];
  assign mant_f   = carry ? 23'h0 : rnd[22:0];
  assign exp_f    = res_exp - {9'b0, ~norm} + {9'b0, carry};

  logic unused_bits;
  assign unused_bits = ^{sq[2*XW-1:XW+32], sq[31:0], ax2[22:0], prod[2*XW-1:XW+33],
                         prod[32:0], diff[37:XW], y[AW+XW-1:56], exp_f[9:8], e_even[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SEED;
      SEED:    state_nxt = ITER;
      ITER:    if (step == 3'(ITERS - 1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step     <= 3'd0;
      a_q      <= '0;
      x        <= '0;
      seed_idx <= '0;
      res_exp  <= '0;
      spec     <= 1'b0;
      spec_val <= 32'h0;
      out_data <= 32'h0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= a_in;
          seed_idx <= {odd_in, in_data[22:23-SEED_BITS]};
          res_exp  <= half_exp;
          spec     <= sp_in;
          spec_val <= sp_val_in;
        end
        SEED: begin
          x    <= XW'({seed_rom[seed_idx], {(32-SEED_BITS){1'b0}}});
          step <= 3'd0;
        end
        ITER: begin
          x    <= x_nxt;
          step <= (step == 3'(ITERS - 1)) ? 3'd0 : step + 3'd1;
        end
        ROUND: out_data <= spec ? spec_val : {1'b0, exp_f[7:0], mant_f};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fsqrt_iter.sv
// Scoreboard bench for fsqrt_iter: integer-sqrt reference, fixed-latency and handshake checks.
module tb_fsqrt_iter;
  localparam int ITERS     = 2;
  localparam int SEED_BITS = 7;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;

  always #5 clk = ~clk;

  fsqrt_iter #(.ITERS(ITERS), .SEED_BITS(SEED_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          tol_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want, input int tol);
    longint d;
    n_checks++;
    d = longint'(got) - longint'(want);
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (tol %0d)", tag, got, want, tol);
    end
  endtask

  function automatic logic [31:0] ref_sqrt(input logic [31:0] op);
    longint ee, a, n, r, b;
`ifdef FSQRT_SPECIAL_EN
    if (op[30:23] == 8'h00) return {op[31], 31'h0};
    if (op[30:23] == 8'hFF && op[22:0] != 23'h0) return 32'h7FC00000;
    if (op[31]) return 32'h7FC00000;
    if (op[30:23] == 8'hFF) return 32'h7F800000;
`else
    if (op[31] && op[30:0] != 31'h0) return 32'h80000000;
`endif
    ee = longint'(op[30:23]) - 127;
    a  = longint'({1'b1, op[22:0]});
    if ((ee & 1) != 0) begin
      a  = a << 1;
      ee = ee - 1;
    end
    n = a << 23;
    r = 0;
    for (int i = 25; i >= 0; i--) begin
      b = r | (longint'(1) << i);
      if (b * b <= n) r = b;
    end
    if (n - r * r > r) r++;
    ee = ee / 2 + 127;
    if (r >= (longint'(1) << 24)) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    return {1'b0, 8'(ee), 23'(r)};
  endfunction

  task automatic run_op(input logic [31:0] op, input int tol, input int hold);
    int          n;
    logic [31:0] held, e;
    int          t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = op;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_wait", 32'(n), 32'd0, 19);
    exp_q.push_back(ref_sqrt(op));
    tol_q.push_back(tol);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", 32'(n), 32'(ITERS + 2), 0);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 32'(exp_q.size()), 32'd1, 0);
    end else begin
      e = exp_q.pop_front();
      t = tol_q.pop_front();
      check("result", out_data, e, t);
    end
    held = out_data;
    repeat (hold) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check("hold_data", out_data, held, 0);
      check("hold_in_ready", 32'(in_ready), 32'd0, 0);
      check("hold_out_valid", 32'(out_valid), 32'd1, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_in_ready", 32'(in_ready), 32'd1, 0);
    check("post_out_valid", 32'(out_valid), 32'd0, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [31:0] op;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0, 0);
    check("rst_out_data", out_data, 32'h0, 0);
    check("rst_in_ready", 32'(in_ready), 32'd1, 0);

    run_op(32'h40800000, 0, 5);   // 4.0 with a stalled consumer
    run_op(32'h3E800000, 0, 0);   // 0.25
    run_op(32'h40000000, 1, 0);   // 2.0
    run_op(32'h3F800000, 1, 0);   // 1.0
    run_op(32'h40100000, 1, 0);   // 2.25
    run_op(32'h00800000, 1, 0);   // smallest normal
    run_op(32'h7F7FFFFF, 1, 0);   // largest normal
    run_op(32'h3FFFFFFF, 1, 0);   // just below 2.0
    run_op(32'hBF800000, 0, 0);   // -1.0
`ifdef FSQRT_SPECIAL_EN
    run_op(32'h7F800000, 0, 0);
    run_op(32'h00000000, 0, 0);
    run_op(32'h80000000, 0, 0);
    run_op(32'h7FC00001, 0, 0);
    run_op(32'h80000123, 0, 0);
`endif

    // reset during ITER discards the operation
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h40800000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (ITERS + 6) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(cnt), 32'd0, 0);
    check("abort_out_data", out_data, 32'h0, 0);
    check("abort_in_ready", 32'(in_ready), 32'd1, 0);

    // reset wins over a simultaneous in_valid
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h41100000;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cnt = 0;
    repeat (ITERS + 6) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    check("rst_dominates", 32'(cnt), 32'd0, 0);

    run_op(32'h40800000, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      op = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(op, 1, (i % 97 == 0) ? 2 : 0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
